// File: rtl/po_pkg.sv
// Shared definitions for the polyhedral-cone point-count front end.
package po_pkg;

  // Loader control states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StStart,
    StRun
  } state_e;

  // Header word field layout.
  localparam int unsigned HDR_CONES_LSB = 0;
  localparam int unsigned HDR_CONES_W   = 4;
  localparam int unsigned HDR_LEN_LSB   = 8;
  localparam int unsigned HDR_LEN_W     = 16;

endpackage

// File: rtl/po_input_loader_if.sv
// Word-stream handshake carrying one problem frame into the loader.
interface po_input_loader_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/po_input_loader.sv
// Frame loader: parses a header, streams the payload into the input-array RAM,
// then starts the core and waits for it to finish. Malformed frames are drained.
module po_input_loader
  import po_pkg::*;
#(
  parameter int unsigned ROWS   = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  po_input_loader_if.slave       s,
  output logic                   ram_wren,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_data,
  output logic [HDR_CONES_W-1:0] number_of_cones,
  output logic                   go_o,
  input  logic                   done_i,
  output logic                   busy,
  output logic                   frame_err,
  output logic [ADDR_W:0]        words_loaded
);

  localparam int unsigned    DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntOne = 1;

  // ROWS only describes the core; reject a meaningless value at elaboration.
  if (ROWS == 0) begin : g_rows_check
    $error("po_input_loader: ROWS must be nonzero");
  end

  state_e                 state_q, state_d;
  logic [ADDR_W:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]        len_q, len_d;
  logic [HDR_CONES_W-1:0] cones_q, cones_d;
  logic                   err_q, err_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   go_q, go_d;

  logic                   beat;
  logic [HDR_LEN_W-1:0]   hdr_len;
  logic                   hdr_bad;
  logic                   final_beat;

  // Ready depends on state only; held low while reset is asserted.
  assign s.s_ready = ~reset & (state_q inside {StIdle, StLoad, StDrain});
  assign beat      = s.s_valid & s.s_ready;

  assign hdr_len    = s.s_data[HDR_LEN_LSB +: HDR_LEN_W];
  assign hdr_bad    = (hdr_len == '0) || (32'(hdr_len) > DEPTH) || s.s_last;
  assign final_beat = ((cnt_q + CntOne) == len_q);

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cones_d = cones_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    go_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (beat) begin
          cones_d = s.s_data[HDR_CONES_LSB +: HDR_CONES_W];
          cnt_d   = '0;
          // N <= DEPTH is checked before use, so ADDR_W+1 bits hold it.
          len_d   = hdr_len[ADDR_W:0];
          err_d   = hdr_bad;
          if (!hdr_bad) begin
            state_d = StLoad;
          end else if (!s.s_last) begin
            state_d = StDrain;
          end
        end
      end
      StLoad: begin
        if (beat) begin
          wr_d   = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = s.s_data;
          cnt_d  = cnt_q + CntOne;
          if (s.s_last && final_beat) begin
            state_d = StStart;
          end else if (s.s_last) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (final_beat) begin
            err_d   = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (beat && s.s_last) begin
          state_d = StIdle;
        end
      end
      StStart: begin
        // go is registered so it lands one cycle after the final write.
        go_d    = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (done_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      cones_q <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cones_q <= cones_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      go_q    <= go_d;
    end
  end

  assign ram_wren        = wr_q;
  assign ram_addr        = addr_q;
  assign ram_data        = data_q;
  assign number_of_cones = cones_q;
  assign go_o            = go_q;
  assign busy            = (state_q != StIdle);
  assign frame_err       = err_q;
  assign words_loaded    = cnt_q;

endmodule

// File: tb/tb_po_input_loader.sv
// Directed bench for po_input_loader with a frame-level reference model.
module tb_po_input_loader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [3:0]        number_of_cones;
  logic              go_o;
  logic              done_i = 1'b0;
  logic              busy;
  logic              frame_err;
  logic [ADDR_W:0]   words_loaded;

  po_input_loader_if #(.DATA_W(DATA_W)) s_if ();

  po_input_loader #(
    .ROWS  (12),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s              (s_if),
    .ram_wren       (ram_wren),
    .ram_addr       (ram_addr),
    .ram_data       (ram_data),
    .number_of_cones(number_of_cones),
    .go_o           (go_o),
    .done_i         (done_i),
    .busy           (busy),
    .frame_err      (frame_err),
    .words_loaded   (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  wr_t         exp_wr[$];
  int          exp_go = 0;
  bit          exp_err;
  int          exp_words;
  logic [3:0]  exp_cones;
  bit          b2b = 1'b0;
  logic        prev_wren = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  wr_t         e;

  logic [31:0] pq[$];
  logic        lq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of the write port and go pulse against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_wren) begin
        check("write_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(ram_addr), 64'(e.addr));
          check("wr_data", 64'(ram_data), 64'(e.data));
          if (b2b && ram_addr != 0) check("wr_back_to_back", 64'(prev_wren), 64'd1);
        end
        last_addr = ram_addr;
      end
      if (go_o) begin
        check("go_expected", 64'(exp_go > 0), 64'd1);
        check("go_after_final_write", 64'(prev_wren && exp_wr.size() == 0), 64'd1);
        check("go_ready_low", 64'(s_if.s_ready), 64'd0);
        if (exp_go > 0) exp_go--;
      end
    end
    prev_wren = ram_wren;
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int t = 0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    s_if.s_last  = l;
    do begin
      @(negedge clk);
      t++;
    end while (!s_if.s_ready && t < 100);
    if (!s_if.s_ready) check("beat_accept_timeout", 64'(s_if.s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic wait_go();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!go_o && t < 1000);
    check("go_seen", 64'(go_o), 64'd1);
  endtask

  task automatic check_idle_status(input string tag);
    check({tag, "_frame_err"}, 64'(frame_err), 64'(exp_err));
    check({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
    check({tag, "_cones"}, 64'(number_of_cones), 64'(exp_cones));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(s_if.s_ready), 64'd1);
  endtask

  // Model the frame from the format rules, then drive it.
  // finish_run=0 leaves the DUT in RUN right after go is seen.
  task automatic send_frame(input string tag, input logic [31:0] hdr, input logic hdr_last,
                            input logic [31:0] pay[$], input logic lst[$],
                            input bit bubble, input bit finish_run);
    int n = int'(hdr[23:8]);
    int i = 0;
    bit go_exp = 1'b0;
    exp_cones = hdr[3:0];
    if (hdr_last || n == 0 || n > int'(DEPTH)) begin
      exp_err   = 1'b1;
      exp_words = 0;
    end else begin
      while (i < pay.size() - 1 && !(lst[i] || i == n - 1)) i++;
      for (int k = 0; k <= i; k++) exp_wr.push_back('{addr: k[ADDR_W-1:0], data: pay[k]});
      exp_words = i + 1;
      go_exp    = lst[i] && (i == n - 1);
      exp_err   = !go_exp;
    end
    if (go_exp) exp_go++;
    b2b = !bubble;

    send_beat(hdr, hdr_last);
    for (int k = 0; k < pay.size(); k++) begin
      if (bubble) begin
        @(posedge clk);
        #1;
      end
      send_beat(pay[k], lst[k]);
    end

    if (go_exp) begin
      wait_go();
      if (!finish_run) return;
      if (done_i) begin
        @(negedge clk);
      end else begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check({tag, "_run_ready_low"}, 64'(s_if.s_ready), 64'd0);
          check({tag, "_run_busy"}, 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1 done_i = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;
        @(negedge clk);
      end
    end else begin
      repeat (3) @(negedge clk);
    end
    check_idle_status(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(s_if.s_ready), 64'd0);
    check({tag, "_wren"}, 64'(ram_wren), 64'd0);
    check({tag, "_addr"}, 64'(ram_addr), 64'd0);
    check({tag, "_data"}, 64'(ram_data), 64'd0);
    check({tag, "_cones"}, 64'(number_of_cones), 64'd0);
    check({tag, "_go"}, 64'(go_o), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(frame_err), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required bench completion");
    $fatal(1);
  end

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_last  = 1'b0;

    // Reset values.
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 64'(s_if.s_ready), 64'd1);
    check("post_reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

    // Nominal frame, continuous valid.
    pq = '{32'hA, 32'hB, 32'hC};
    lq = '{1'b0, 1'b0, 1'b1};
    send_frame("nominal", 32'h0000_0303, 1'b0, pq, lq, 1'b0, 1'b1);
    check("nominal_words_lit", 64'(words_loaded), 64'd3);
    check("nominal_cones_lit", 64'(number_of_cones), 64'd3);
    check("nominal_last_addr_lit", 64'(last_addr), 64'd2);

    // Bubbles; done held high throughout is ignored until RUN.
    done_i = 1'b1;
    send_frame("bubble", 32'h0000_0303, 1'b0, pq, lq, 1'b1, 1'b1);
    done_i = 1'b0;

    // Early last.
    pq = '{32'h21, 32'h22};
    lq = '{1'b0, 1'b1};
    send_frame("early", 32'h0000_0404, 1'b0, pq, lq, 1'b0, 1'b1);
    check("early_err_lit", 64'(frame_err), 64'd1);
    check("early_words_lit", 64'(words_loaded), 64'd2);

    // Next valid header clears the error.
    pq = '{32'h31, 32'h32};
    lq = '{1'b0, 1'b1};
    send_frame("recover", 32'h0000_0209, 1'b0, pq, lq, 1'b0, 1'b1);
    check("recover_err_lit", 64'(frame_err), 64'd0);

    // Bad headers: N=0 carrying last, then N=DEPTH+1 drained.
    pq.delete();
    lq.delete();
    send_frame("bad_n0", 32'h0000_0007, 1'b1, pq, lq, 1'b0, 1'b1);
    pq = '{32'h1, 32'h2};
    lq = '{1'b0, 1'b1};
    send_frame("bad_big", 32'hFF01_01F2, 1'b0, pq, lq, 1'b0, 1'b1);
    check("bad_big_words_lit", 64'(words_loaded), 64'd0);

    // Late last: N=2 with last on a third beat.
    pq = '{32'h5, 32'h6, 32'h7};
    lq = '{1'b0, 1'b0, 1'b1};
    send_frame("late", 32'h0000_0201, 1'b0, pq, lq, 1'b0, 1'b1);

    // Full depth.
    pq.delete();
    lq.delete();
    for (int k = 0; k < int'(DEPTH); k++) begin
      pq.push_back(32'h100 + k);
      lq.push_back(k == int'(DEPTH) - 1);
    end
    send_frame("full", 32'h0001_0005, 1'b0, pq, lq, 1'b0, 1'b1);
    check("full_last_addr_lit", 64'(last_addr), 64'd255);
    check("full_words_lit", 64'(words_loaded), 64'd256);

    // Reset mid-LOAD after 2 of 5 beats.
    exp_wr.push_back('{addr: 8'd0, data: 32'h11});
    exp_wr.push_back('{addr: 8'd1, data: 32'h22});
    b2b = 1'b1;
    send_beat(32'h0000_0501, 1'b0);
    send_beat(32'h11, 1'b0);
    send_beat(32'h22, 1'b0);
    @(negedge clk);
    check("midload_words", 64'(words_loaded), 64'd2);
    check("midload_busy", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1 check_all_zero("midload_reset");
    check("midload_writes_done", 64'(exp_wr.size()), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid-RUN.
    pq = '{32'hA, 32'hB, 32'hC};
    lq = '{1'b0, 1'b0, 1'b1};
    send_frame("prerun", 32'h0000_0303, 1'b0, pq, lq, 1'b0, 1'b0);
    check("prerun_busy", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1 check_all_zero("midrun_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrun_release_ready", 64'(s_if.s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Nominal frame after the resets.
    pq = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    lq = '{1'b0, 1'b0, 1'b0, 1'b1};
    send_frame("after_reset", 32'hAB00_040C, 1'b0, pq, lq, 1'b0, 1'b1);
    check("after_reset_cones_lit", 64'(number_of_cones), 64'd12);

    check("end_writes_drained", 64'(exp_wr.size()), 64'd0);
    check("end_go_drained", 64'(exp_go), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/po_input_loader.md
# po_input_loader

Upstream stage of the polyhedral-cone point-count core. Accepts one problem frame from a word stream with a valid/ready handshake, writes its payload into the core's input-array RAM port, latches the cone count, then pulses `go_o`. It holds off further frames until the core reports `done_i`. Malformed frames are drained and flagged and never start the core.

## Interface
Parameters:
- `ROWS`, 12: matrix dimension forwarded to the core; informational only, no effect on loader logic.
- `DATA_W`, 32: stream and RAM word width.
- `ADDR_W`, 8: RAM address width; `DEPTH = 2**ADDR_W`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `s_valid`  in  1  stream beat valid.
- `s_ready`  out  1  loader can accept a beat.
- `s_data`  in  DATA_W  stream word.
- `s_last`  in  1  final beat of the frame.
- `ram_wren`  out  1  write strobe to input-array port A.
- `ram_addr`  out  ADDR_W  write address.
- `ram_data`  out  DATA_W  write data.
- `number_of_cones`  out  4  cone count from the header, held until the next header is accepted.
- `go_o`  out  1  single-cycle start pulse to the core.
- `done_i`  in  1  core completion, sampled as a level.
- `busy`  out  1  high in every state except IDLE.
- `frame_err`  out  1  sticky error flag, cleared when the next header is accepted.
- `words_loaded`  out  ADDR_W+1  payload words written for the current or last frame.

## Operation
- Frame format: beat 0 is the header. Header bits [3:0] hold the cone count and bits [23:8] hold the payload length N. Beats 1..N are payload. `s_last` must be set on beat N and only there.
- A beat transfers when `s_valid && s_ready`.
- States and transitions:
  - IDLE: `s_ready`=1. A header beat moves to LOAD if the header is valid.
  - A header is invalid if N==0, N>DEPTH, or `s_last` is set on the header. An invalid header sets `frame_err` and moves to DRAIN, or stays in IDLE if it carried `s_last`.
  - LOAD: `s_ready`=1. Payload beat k (0-based) is written to address k.
    - `s_last` on beat N-1: go to START.
    - `s_last` before beat N-1 (early): set `frame_err`, go to IDLE.
    - Beat N-1 without `s_last` (late): set `frame_err`, go to DRAIN.
  - DRAIN: `s_ready`=1, no writes. Go to IDLE on the `s_last` beat.
  - START: `s_ready`=0, `go_o`=1 for exactly one cycle, then go to RUN.
  - RUN: `s_ready`=0. Go to IDLE on the first cycle with `done_i`=1.
- Writes already issued for a bad frame are not undone. RAM content is undefined after an error.
- Width rules:
  - `words_loaded` counts payload beats accepted in LOAD.
  - The address counter is ADDR_W bits and never wraps, because N≤DEPTH is enforced.
  - Header bits outside [23:8] and [3:0] are ignored.

## Timing
- Reset values:
  - `s_ready`=0 during reset, then 1 in IDLE from the first cycle after release.
  - `ram_wren`=0, `ram_addr`=0, `ram_data`=0.
  - `number_of_cones`=0, `go_o`=0, `busy`=0, `frame_err`=0, `words_loaded`=0.
- `s_ready` is a combinational decode of the state register only; it never depends on `s_valid`.
- RAM write outputs are registered. A beat accepted in cycle t appears on `ram_wren/addr/data` in cycle t+1. Back-to-back beats give one write per cycle.
- `go_o` is high in the cycle after the last payload write is driven, so all writes complete before the core starts.
- `number_of_cones` is valid from the cycle after header acceptance, at least N+1 cycles before `go_o`.
- `done_i` is ignored outside RUN. A `done_i` that is already high on RUN entry ends RUN after one cycle.
- Reset asserted mid-frame or in RUN forces IDLE and zeroes outputs asynchronously. Beats in flight are lost, and the upstream source must restart from a header.

## Structure
- Shared package `po_pkg` holds:
  - the state enum (IDLE, LOAD, DRAIN, START, RUN);
  - header field constants (`HDR_CONES_LSB`=0, `HDR_CONES_W`=4, `HDR_LEN_LSB`=8, `HDR_LEN_W`=16).
- Single module; no sub-module. The FSM, address counter and write register fit comfortably in one file.

## Test plan
- Nominal frame: header 0x0000_0303 (N=3, cones=3) then payload 0xA,0xB,0xC with `s_last` on 0xC, `s_valid` continuous. Expect:
  - writes (0,0xA),(1,0xB),(2,0xC) on consecutive cycles;
  - `number_of_cones`=3 and `words_loaded`=3;
  - one `go_o` pulse the cycle after the write at address 2;
  - `s_ready`=0 until `done_i`=1, then IDLE.
- Bubbles: same frame with `s_valid` toggling every cycle. Expect identical write sequence and values, and one `go_o`.
- Early last: N=4 header, `s_last` on payload beat 2. Expect `frame_err`=1, no `go_o`, IDLE, `words_loaded`=2. The next valid header clears `frame_err`.
- Bad header: N=0, then N=DEPTH+1 followed by 2 beats ending in `s_last`. Expect `frame_err` for each, no writes for the second frame (DRAIN), no `go_o`.
- Full depth: N=DEPTH with incrementing payload. Expect the last write at address DEPTH-1, no wrap, `words_loaded`=DEPTH, then `go_o`.
- Reset mid-LOAD after 2 of 5 beats, then reset mid-RUN. Expect all outputs zero immediately, IDLE on release, and a following nominal frame that completes correctly.
